// File: rtl/adv7513_reg_dump_if.sv
// Bus between the register-dump sequencer, its register-read stage and the record consumer.
// A record moves on every rising clk edge where out_valid and out_ready are both high; out_valid and the payload hold until then.
interface adv7513_reg_dump_if;
    logic       rd_start;
    logic [7:0] rd_addr;
    logic       rd_done;
    logic [7:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_addr;
    logic [7:0] out_data;
    logic       out_timeout;

    modport master (
        output rd_start, rd_addr, out_valid, out_addr, out_data, out_timeout,
        input  rd_done, rd_data, out_ready
    );

    modport slave (
        input  rd_start, rd_addr, out_valid, out_addr, out_data, out_timeout,
        output rd_done, rd_data, out_ready
    );
endinterface

// File: rtl/adv7513_reg_dump.sv
// Walks an ADV7513 register range, reading one address at a time through the read stage.
// It emits one record per address, and a record is marked as a timeout if the read stage never answers.
module adv7513_reg_dump #(
    parameter logic [7:0]  FIRST_ADDR     = 8'h00,
    parameter logic [7:0]  LAST_ADDR      = 8'hFF,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               go,
    output logic               busy,
    output logic               finished,
    output logic [7:0]         err_count,
    output logic [2:0]         o_dbg_state,
    adv7513_reg_dump_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_PUSH   = 3'd3,
        S_FINISH = 3'd4
    } state_e;

    state_e      r_state;
    state_e      w_next;
    logic        r_rd_done_q;
    logic [15:0] r_tmo_cnt;
    logic [7:0]  r_rd_addr;
    logic [7:0]  r_out_addr;
    logic [7:0]  r_out_data;
    logic        r_out_timeout;
    logic [7:0]  r_err_count;
    logic        w_edge;
    logic        w_tmo;
    logic        w_xfer;
    logic        w_last;

    // rd_done is a level flag that may still be high from an earlier read, so only a rise completes a read
    assign w_edge = bus.rd_done & ~r_rd_done_q;
    assign w_tmo  = (r_tmo_cnt == TIMEOUT_CYCLES - 16'd1);
    assign w_xfer = (r_state == S_PUSH) && bus.out_ready;
    assign w_last = (r_rd_addr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (go) w_next = (FIRST_ADDR <= LAST_ADDR) ? S_ISSUE : S_FINISH;
            S_ISSUE:  w_next = S_WAIT;
            S_WAIT:   if (w_edge || w_tmo) w_next = S_PUSH;
            S_PUSH:   if (w_xfer) w_next = w_last ? S_FINISH : S_ISSUE;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy            = (r_state != S_IDLE);
        finished        = (r_state == S_FINISH);
        bus.rd_start    = (r_state == S_ISSUE);
        bus.out_valid   = (r_state == S_PUSH);
        bus.rd_addr     = r_rd_addr;
        bus.out_addr    = r_out_addr;
        bus.out_data    = r_out_data;
        bus.out_timeout = r_out_timeout;
        err_count       = r_err_count;
        o_dbg_state     = r_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_done_q   <= 1'b0;
            r_tmo_cnt     <= 16'd0;
            r_rd_addr     <= 8'h00;
            r_out_addr    <= 8'h00;
            r_out_data    <= 8'h00;
            r_out_timeout <= 1'b0;
            r_err_count   <= 8'h00;
        end else begin
            r_rd_done_q <= bus.rd_done;
            case (r_state)
                S_IDLE: begin
                    if (go && (FIRST_ADDR <= LAST_ADDR)) begin
                        r_rd_addr   <= FIRST_ADDR;
                        r_err_count <= 8'h00;
                    end
                end
                S_ISSUE: r_tmo_cnt <= 16'd0;
                S_WAIT: begin
                    if (w_edge) begin
                        r_out_data    <= bus.rd_data;
                        r_out_addr    <= r_rd_addr;
                        r_out_timeout <= 1'b0;
                    end else if (w_tmo) begin
                        r_out_data    <= 8'h00;
                        r_out_addr    <= r_rd_addr;
                        r_out_timeout <= 1'b1;
                        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                // Testing LAST_ADDR before incrementing keeps a dump ending at 8'hFF from wrapping
                S_PUSH: if (w_xfer && !w_last) r_rd_addr <= r_rd_addr + 8'd1;
                default: ;
            endcase
        end
    end
endmodule
